// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and widths for the bcd converter scheduler.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BIN_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, DISCARD, CAPTURE, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/bcd_scheduler.sv
// bcd_scheduler: round-robin sharing of one bcd converter, discarding the
// first ready edge after load so only results computed on stable input return.
module bcd_scheduler import bcd_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [BIN_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       resp_sign,
  output logic [DIGIT_W-1:0]         resp_hundreds,
  output logic [DIGIT_W-1:0]         resp_tens,
  output logic [DIGIT_W-1:0]         resp_ones,
  output logic                       resp_err,
  output logic                       busy,
  output logic [BIN_W-1:0]           conv_binary,
  input  logic                       conv_sign,
  input  logic [DIGIT_W-1:0]         conv_hundreds,
  input  logic [DIGIT_W-1:0]         conv_tens,
  input  logic [DIGIT_W-1:0]         conv_ones,
  input  logic                       conv_data_ready
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [IW-1:0] ptr, id, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic arb_any, rdy_d, rise, waiting, expire, take;
  logic [15:0] cnt;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );
  assign rise = conv_data_ready & ~rdy_d;
  assign waiting = state == DISCARD || state == CAPTURE;
  assign expire = waiting && cnt == 16'(TIMEOUT - 1);
  assign take = state == IDLE && arb_any;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // A timeout overrides any ready edge seen in the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = arb_any ? LOAD : IDLE;
      LOAD:    state_n = DISCARD;
      DISCARD: state_n = expire ? RESP : rise ? CAPTURE : DISCARD;
      CAPTURE: state_n = (expire || rise) ? RESP : CAPTURE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_sign <= 1'b0;
      resp_hundreds <= '0;
      resp_tens <= '0;
      resp_ones <= '0;
      resp_err <= 1'b0;
      conv_binary <= '0;
      ptr <= '0;
      id <= '0;
      rdy_d <= 1'b0;
      cnt <= '0;
    end else begin
      rdy_d <= conv_data_ready;
      grant <= take ? arb_gnt : '0;
      resp_valid <= waiting && state_n == RESP;
      cnt <= state == LOAD ? '0 : waiting ? cnt + 16'd1 : cnt;
      if (take) begin
        id <= arb_idx;
        conv_binary <= req_data[BIN_W*arb_idx +: BIN_W];
      end
      if (waiting && state_n == RESP) begin
        resp_id <= id;
        resp_err <= expire;
        resp_sign <= conv_sign & ~expire;
        resp_hundreds <= expire ? '0 : conv_hundreds;
        resp_tens <= expire ? '0 : conv_tens;
        resp_ones <= expire ? '0 : conv_ones;
      end
      if (state == RESP) ptr <= id == IW'(NUM_REQ - 1) ? '0 : id + 1'b1;
    end
  end
endmodule

// File: tb/tb_bcd_scheduler.sv
// tb_bcd_scheduler: directed tests against a mock converter that can run
// freely (periodic ready pulses) or be driven cycle by cycle from the tasks.
module tb_bcd_scheduler;
  logic clk = 0, rst = 1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] grant;
  logic resp_valid, resp_sign, resp_err, busy;
  logic [1:0] resp_id;
  logic [3:0] rh, rt, ro;
  logic [7:0] conv_binary;
  logic conv_sign, conv_data_ready;
  logic [3:0] ch, ct, co;
  logic manual = 0, m_rdy = 0, m_sign = 0;
  logic [3:0] mh = 0, mt = 0, mo = 0;
  logic a_rdy;
  logic [1:0] ph;
  logic [7:0] snap, mag;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  bcd_scheduler #(.NUM_REQ(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sign(resp_sign),
    .resp_hundreds(rh), .resp_tens(rt), .resp_ones(ro), .resp_err(resp_err),
    .busy(busy), .conv_binary(conv_binary), .conv_sign(conv_sign),
    .conv_hundreds(ch), .conv_tens(ct), .conv_ones(co),
    .conv_data_ready(conv_data_ready)
  );

  // Free-running converter: samples its input, then pulses ready two cycles later.
  always @(posedge clk)
    if (rst || manual) begin
      ph <= 0;
      a_rdy <= 0;
      snap <= 0;
    end else begin
      ph <= ph == 2 ? 2'd0 : ph + 2'd1;
      a_rdy <= ph == 2;
      if (ph == 0) snap <= conv_binary;
    end
  assign mag = snap[7] ? 8'(~snap + 8'd1) : snap;
  assign conv_data_ready = manual ? m_rdy : a_rdy;
  assign conv_sign = manual ? m_sign : snap[7];
  assign ch = manual ? mh : 4'(mag / 100);
  assign ct = manual ? mt : 4'((mag / 10) % 10);
  assign co = manual ? mo : 4'(mag % 10);

  task automatic request(input int i, input logic [7:0] d, output logic [3:0] g);
    @(negedge clk);
    req[i] = 1;
    req_data[8*i +: 8] = d;
    @(negedge clk);
    g = grant;
    req = '0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({grant, resp_valid, busy, conv_binary} !== 14'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b/%b/%b/%h want all 0", grant, resp_valid, busy, conv_binary);
    end
    checks++;
    if ({resp_id, resp_sign, rh, rt, ro, resp_err} !== 16'd0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0", {resp_id, resp_sign, rh, rt, ro, resp_err});
    end
    rst = 0;
  endtask

  task automatic test_single;
    logic [3:0] g;
    bit ok;
    request(2, 8'd123, g);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", g); end
    checks++;
    if (conv_binary !== 8'd123) begin errors++; $display("FAIL single_binary: got %0d want 123", conv_binary); end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: grant %b busy %b want 0000 1", grant, busy);
    end
    wait_resp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_wait: no resp_valid within bound"); end
    checks++;
    if ({resp_id, resp_sign, rh, rt, ro, resp_err} !== {2'd2, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_resp: got id %0d s %b %0d%0d%0d err %b want 2 0 123 0", resp_id, resp_sign, rh, rt, ro, resp_err);
    end
  endtask

  task automatic test_conversions;
    logic [3:0] g;
    bit ok;
    logic [7:0] din [4] = '{8'hDA, 8'h80, 8'h7F, 8'h00};
    int idx [4] = '{0, 1, 3, 0};
    logic [12:0] exp [4] = '{{1'b1, 4'd0, 4'd3, 4'd8}, {1'b1, 4'd1, 4'd2, 4'd8},
                             {1'b0, 4'd1, 4'd2, 4'd7}, {1'b0, 4'd0, 4'd0, 4'd0}};
    for (int v = 0; v < 4; v++) begin
      request(idx[v], din[v], g);
      wait_resp(ok);
      checks++;
      if (!ok || resp_err !== 1'b0 || resp_id !== 2'(idx[v]) || {resp_sign, rh, rt, ro} !== exp[v]) begin
        errors++;
        $display("FAIL conv_%h: got ok %b id %0d err %b %h want id %0d %h", din[v], ok, resp_id, resp_err, {resp_sign, rh, rt, ro}, idx[v], exp[v]);
      end
    end
  endtask

  task automatic test_stale_guard;
    logic [3:0] g;
    manual = 1;
    request(1, 8'd45, g);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL stale_grant: got %b want 0010", g); end
    @(negedge clk);
    {m_rdy, m_sign, mh, mt, mo} = {1'b1, 1'b1, 4'd9, 4'd9, 4'd9};
    @(negedge clk);
    m_rdy = 0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL stale_taken: resp_valid %b want 0", resp_valid); end
    {m_rdy, m_sign, mh, mt, mo} = {1'b1, 1'b0, 4'd0, 4'd4, 4'd5};
    @(negedge clk);
    m_rdy = 0;
    checks++;
    if (resp_valid !== 1'b1 || {resp_id, resp_sign, rh, rt, ro, resp_err} !== {2'd1, 1'b0, 4'd0, 4'd4, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL stale_resp: valid %b id %0d s %b %0d%0d%0d err %b want 1 1 0 045 0", resp_valid, resp_id, resp_sign, rh, rt, ro, resp_err);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || {rh, rt, ro} !== 12'h045) begin
      errors++;
      $display("FAIL stale_hold: valid %b digits %h want 0 045", resp_valid, {rh, rt, ro});
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] g;
    bit ok, seen;
    request(2, 8'd200, g);
    checks++;
    if (g !== 4'b0100) begin errors++; $display("FAIL rmid_grant: got %b want 0100", g); end
    @(negedge clk);
    m_rdy = 1;
    @(negedge clk);
    m_rdy = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({grant, resp_valid, busy, conv_binary, rh, rt, ro} !== 26'd0) begin
      errors++;
      $display("FAIL rmid_async: grant %b valid %b busy %b bin %h digits %h want 0", grant, resp_valid, busy, conv_binary, {rh, rt, ro});
    end
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      m_rdy = k == 2;
      @(negedge clk);
      if (resp_valid || busy) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rmid_silent: got resp_valid/busy after reset want none"); end
    manual = 0;
    req = 4'b1010;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL rmid_ptr: got %b want 0010", grant); end
    req = '0;
    wait_resp(ok);
    checks++;
    if (!ok || resp_id !== 2'd1) begin errors++; $display("FAIL rmid_resp: ok %b id %0d want 1 1", ok, resp_id); end
  endtask

  task automatic test_timeout;
    logic [3:0] g;
    bit early, ok;
    manual = 1;
    request(1, 8'd77, g);
    checks++;
    if (g !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b want 0010", g); end
    @(negedge clk);
    early = resp_valid;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (resp_valid) early = 1;
      if (k == 9) {m_rdy, m_sign, mh, mt, mo} = {1'b1, 1'b0, 4'd1, 4'd1, 4'd1};
    end
    checks++;
    if (early) begin errors++; $display("FAIL to_early: resp_valid before cycle 10 want none"); end
    @(negedge clk);
    m_rdy = 0;
    checks++;
    if (resp_valid !== 1'b1 || {resp_id, resp_sign, rh, rt, ro, resp_err, busy} !== {2'd1, 1'b0, 12'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL to_resp: valid %b id %0d s %b %h err %b busy %b want 1 1 0 000 1 1", resp_valid, resp_id, resp_sign, {rh, rt, ro}, resp_err, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL to_idle: busy %b valid %b want 0 0", busy, resp_valid); end
    req = 4'b1011;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL to_ptr: got %b want 1000", grant); end
    req = '0;
    wait_resp(ok);
    checks++;
    if (!ok || resp_id !== 2'd3 || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL to_second: ok %b id %0d err %b want 1 3 1", ok, resp_id, resp_err);
    end
    manual = 0;
  endtask

  task automatic test_back_to_back;
    int gi [5], ri [5], ng, nr;
    logic [7:0] rd [5];
    rst = 1;
    @(negedge clk);
    rst = 0;
    req_data = {8'd44, 8'd33, 8'd22, 8'd11};
    req = 4'b1111;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 300 && nr < 5; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if (grant[b] && ng < 5) begin gi[ng] = b; ng++; end
      if (resp_valid) begin ri[nr] = resp_id; rd[nr] = {rt, ro}; nr++; end
    end
    req = '0;
    checks++;
    if (ng != 5 || nr != 5) begin errors++; $display("FAIL rr_count: grants %0d resps %0d want 5 5", ng, nr); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k < ng && k < nr && (gi[k] != k % 4 || ri[k] != k % 4 || rd[k] !== {4'(k % 4 + 1), 4'(k % 4 + 1)})) begin
        errors++;
        $display("FAIL rr_order%0d: grant %0d id %0d digits %h want %0d", k, gi[k], ri[k], rd[k], k % 4);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_conversions;
    test_stale_guard;
    test_reset_mid;
    test_timeout;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
